branch_predict_unit: RTL and testbench

//  Successor to the combinational branch condition unit. Predicts conditional branches at IF with a

---
 rtl/branch_predict_unit_pkg.sv | 34 +++
 rtl/branch_predict_unit_branch_cond.sv | 32 +++
 rtl/branch_predict_unit.sv | 145 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch prediction unit.
//   br_func3_e : conditional-branch func3 codes (BR_BEQ..BR_BGEU); 3'b010/3'b011 are undefined
//   bp_cnt_e   : 2-bit saturating counter encodings (BP_SNT, BP_WNT, BP_WT, BP_ST)
//   cnt_update : saturating increment/decrement of a prediction counter
package branch_predict_unit_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_func3_e;

    typedef enum logic [1:0] {
        BP_SNT = 2'd0,
        BP_WNT = 2'd1,
        BP_WT  = 2'd2,
        BP_ST  = 2'd3
    } bp_cnt_e;

    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != BP_ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != BP_SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_branch_cond.sv
// Combinational branch condition evaluation at EX.
//   func3      in  branch type
//   z/c/s/v    in  ALU flags of rs1-rs2
//   cond       out resolved outcome (0 for undefined func3)
//   illegal    out func3 is not a defined conditional-branch code
module branch_cond
    import branch_predict_unit_pkg::*;
(
    input  logic [2:0] func3,
    input  logic       z,
    input  logic       c,
    input  logic       s,
    input  logic       v,
    output logic       cond,
    output logic       illegal
);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (func3)
            BR_BEQ:  cond = z;
            BR_BNE:  cond = ~z;
            BR_BLT:  cond = s ^ v;
            BR_BGE:  cond = ~(s ^ v);
            BR_BLTU: cond = ~c;
            BR_BGEU: cond = c;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: 2-bit saturating counter table looked up at IF, resolved and
// trained at EX, with a registered redirect (mispredict) pulse one cycle after resolve.
//   clk, rst_n            clock; synchronous active-low reset
//   if_valid, if_pc       IF lookup request / fetch PC
//   if_pred_taken         prediction from the registered table (0 when !if_valid)
//   ex_valid, ex_pc       EX conditional branch present / its PC
//   ex_func3, ex_z..ex_v  branch type and ALU flags
//   ex_pred_taken         prediction that travelled with the branch
//   mispredict, actual_taken, res_valid, illegal_br   registered resolve results
// Optional build macro BPU_STATS_EN adds stat_branches / stat_mispred counters.
// Parameters: IDX_W (table index width), GSHARE (0 bimodal, 1 gshare), CNT_INIT (reset counter).
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned GSHARE   = 0,
    parameter int unsigned CNT_INIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [2:0]  ex_func3,
    input  logic        ex_z,
    input  logic        ex_c,
    input  logic        ex_s,
    input  logic        ex_v,
    input  logic        ex_pred_taken,
    output logic        mispredict,
    output logic        actual_taken,
    output logic        res_valid,
    output logic        illegal_br
`ifdef BPU_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    logic [1:0]       cnt_q [ENTRIES];
    logic [1:0]       cnt_d [ENTRIES];
    logic [IDX_W-1:0] ghr_q, ghr_d;
    logic             res_valid_q, res_valid_d;
    logic             actual_taken_q, actual_taken_d;
    logic             mispredict_q, mispredict_d;
    logic             illegal_br_q, illegal_br_d;

    logic [IDX_W-1:0] hist;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             cond;
    logic             illegal;
    logic             train;
    logic             pc_unused;

    // PC bits outside the index field carry no information for the table.
    assign pc_unused = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};

    branch_cond u_branch_cond (
        .func3   (ex_func3),
        .z       (ex_z),
        .c       (ex_c),
        .s       (ex_s),
        .v       (ex_v),
        .cond    (cond),
        .illegal (illegal)
    );

    // Both ports hash with the pre-edge history; the GHR only moves on a legal resolve.
    assign hist   = (GSHARE != 0) ? ghr_q : '0;
    assign if_idx = if_pc[IDX_W+1:2] ^ hist;
    assign ex_idx = ex_pc[IDX_W+1:2] ^ hist;
    assign train  = ex_valid & ~illegal;

    // Read straight from the registered table: a same-cycle update is not bypassed.
    assign if_pred_taken = if_valid & cnt_q[if_idx][1];

    always_comb begin
        cnt_d          = cnt_q;
        ghr_d          = ghr_q;
        res_valid_d    = ex_valid;
        actual_taken_d = ex_valid & cond;
        mispredict_d   = ex_valid & (cond ^ ex_pred_taken);
        illegal_br_d   = ex_valid & illegal;
        if (train) begin
            cnt_d[ex_idx] = cnt_update(cnt_q[ex_idx], cond);
            ghr_d         = {ghr_q[IDX_W-2:0], cond};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= 2'(CNT_INIT);
            end
            ghr_q          <= '0;
            res_valid_q    <= 1'b0;
            actual_taken_q <= 1'b0;
            mispredict_q   <= 1'b0;
            illegal_br_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            ghr_q          <= ghr_d;
            res_valid_q    <= res_valid_d;
            actual_taken_q <= actual_taken_d;
            mispredict_q   <= mispredict_d;
            illegal_br_q   <= illegal_br_d;
        end
    end

    assign res_valid    = res_valid_q;
    assign actual_taken = actual_taken_q;
    assign mispredict   = mispredict_q;
    assign illegal_br   = illegal_br_q;

`ifdef BPU_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    // Counted at the edge that raises the pulse, so the totals include the pulse on display.
    always_comb begin
        stat_branches_d = stat_branches_q + {31'd0, res_valid_d};
        stat_mispred_d  = stat_mispred_q + {31'd0, mispredict_d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [2:0]  ex_func3;
    logic        ex_z, ex_c, ex_s, ex_v;
    logic        ex_pred_taken;

    logic        pred_b, misp_b, act_b, rv_b, ill_b;
    logic        pred_g, misp_g, act_g, rv_g, ill_g;
`ifdef BPU_STATS_EN
    logic [31:0] st_br_b, st_mp_b, st_br_g, st_mp_g;
`endif

    int unsigned vectors;
    int unsigned miscompares;

    // Reference model state
    logic [1:0]  mcnt   [64];
    logic [1:0]  mcnt_g [64];
    logic [5:0]  mghr;
    int unsigned m_br, m_mp;
    logic [3:0]  exp_q [$];

    branch_predict_unit dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(pred_b),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_func3(ex_func3), .ex_z(ex_z), .ex_c(ex_c),
        .ex_s(ex_s), .ex_v(ex_v), .ex_pred_taken(ex_pred_taken), .mispredict(misp_b),
        .actual_taken(act_b), .res_valid(rv_b), .illegal_br(ill_b)
`ifdef BPU_STATS_EN
        , .stat_branches(st_br_b), .stat_mispred(st_mp_b)
`endif
    );

    branch_predict_unit #(.GSHARE(1)) dut_g (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(pred_g),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_func3(ex_func3), .ex_z(ex_z), .ex_c(ex_c),
        .ex_s(ex_s), .ex_v(ex_v), .ex_pred_taken(ex_pred_taken), .mispredict(misp_g),
        .actual_taken(act_g), .res_valid(rv_g), .illegal_br(ill_g)
`ifdef BPU_STATS_EN
        , .stat_branches(st_br_g), .stat_mispred(st_mp_g)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic mcond(input logic [2:0] f, input logic z, c, s, v);
        case (f)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return s != v;
            3'b101:  return s == v;
            3'b110:  return !c;
            3'b111:  return c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] msat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mcnt[i]   = 2'd1;
            mcnt_g[i] = 2'd1;
        end
        mghr = '0;
        m_br = 0;
        m_mp = 0;
    endtask

    // One clock: push the expected pulses, let the edge happen, update the model, compare.
    task automatic tick();
        logic       cd, il;
        logic [5:0] bi, gi;
        logic [3:0] e;
        cd = mcond(ex_func3, ex_z, ex_c, ex_s, ex_v);
        il = (ex_func3 == 3'b010) || (ex_func3 == 3'b011);
        bi = ex_pc[7:2];
        gi = bi ^ mghr;
        if (!rst_n)        e = 4'b0000;
        else if (ex_valid) e = {1'b1, cd, cd ^ ex_pred_taken, il};
        else               e = 4'b0000;
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (ex_valid) begin
            m_br++;
            if (cd ^ ex_pred_taken) m_mp++;
            if (!il) begin
                mcnt[bi]   = msat(mcnt[bi], cd);
                mcnt_g[gi] = msat(mcnt_g[gi], cd);
                mghr       = {mghr[4:0], cd};
            end
        end
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("pulses", {28'd0, rv_b, act_b, misp_b, ill_b}, {28'd0, e});
            chk("pulses_g", {28'd0, rv_g, act_g, misp_g, ill_g}, {28'd0, e});
        end
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic [2:0] f, input logic [3:0] zcsv,
                          input logic p);
        ex_valid      = 1'b1;
        ex_pc         = pc;
        ex_func3      = f;
        {ex_z, ex_c, ex_s, ex_v} = zcsv;
        ex_pred_taken = p;
    endtask

    task automatic br(input logic [31:0] pc, input logic [2:0] f, input logic [3:0] zcsv,
                      input logic p);
        set_ex(pc, f, zcsv, p);
        tick();
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        tick();
    endtask

    task automatic look(input logic v, input logic [31:0] pc, input string tag);
        logic [5:0] bi;
        bi       = pc[7:2];
        if_valid = v;
        if_pc    = pc;
        #1;
        chk(tag, {31'd0, pred_b}, {31'd0, v & mcnt[bi][1]});
        chk({tag, "_g"}, {31'd0, pred_g}, {31'd0, v & mcnt_g[bi ^ mghr][1]});
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_reset();
        rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_pc = '0;
        ex_func3 = '0; ex_z = 0; ex_c = 0; ex_s = 0; ex_v = 0; ex_pred_taken = 0;

        // 1: reset state
        tick();
        tick();
        rst_n = 1'b1;
        look(1'b1, 32'h40, "rst_pred");
        chk("rst_pred_const", {31'd0, pred_b}, 32'd0);
        look(1'b0, 32'h40, "novalid_pred");
        idle();

        // 2: BEQ taken at 0x40 twice, counter 1->2->3
        br(32'h40, 3'b000, 4'b1000, 1'b0);
        chk("beq_actual", {31'd0, act_b}, 32'd1);
        chk("beq_misp", {31'd0, misp_b}, 32'd1);
        br(32'h40, 3'b000, 4'b1000, 1'b0);
        idle();
        look(1'b1, 32'h40, "beq_trained");
        chk("beq_trained_const", {31'd0, pred_b}, 32'd1);

        // 3: saturation at 0x80, then one not-taken
        for (int i = 0; i < 4; i++) br(32'h80, 3'b000, 4'b1000, 1'b1);
        br(32'h80, 3'b000, 4'b0000, 1'b1);
        idle();
        look(1'b1, 32'h80, "sat_pred");
        chk("sat_pred_const", {31'd0, pred_b}, 32'd1);

        // 4: func3 x flag sweep, back-to-back resolves
        for (int f = 0; f < 8; f++) begin
            for (int fl = 0; fl < 16; fl++) begin
                br(32'h200 + 32'(f * 4), 3'(f), 4'(fl), 1'($urandom_range(0, 1)));
            end
        end
        br(32'h3F0, 3'b010, 4'b1000, 1'b1);
        br(32'h3F0, 3'b011, 4'b0100, 1'b0);
        br(32'h3F0, 3'b010, 4'b1111, 1'b1);
        idle();
        look(1'b1, 32'h3F0, "illegal_notrain");
        chk("illegal_notrain_const", {31'd0, pred_b}, 32'd0);

        // 5: same-cycle lookup and train on idx 5
        for (int i = 0; i < 3; i++) br(32'h14, 3'b000, 4'b0000, 1'b0);
        br(32'h14, 3'b000, 4'b1000, 1'b0);
        idle();
        set_ex(32'h14, 3'b000, 4'b1000, 1'b0);
        look(1'b1, 32'h14, "samecyc_old");
        chk("samecyc_old_const", {31'd0, pred_b}, 32'd0);
        tick();
        ex_valid = 1'b0;
        look(1'b1, 32'h14, "samecyc_new");
        chk("samecyc_new_const", {31'd0, pred_b}, 32'd1);
        idle();

        // 6: reset mid-burst drops the in-flight resolve and clears history
        br(32'h8, 3'b000, 4'b1000, 1'b0);
        br(32'hC, 3'b001, 4'b0000, 1'b1);
        set_ex(32'h10, 3'b000, 4'b1000, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
        look(1'b1, 32'h40, "post_rst");
        chk("post_rst_const", {31'd0, pred_g}, 32'd0);

        // gshare: history taken,taken makes 0x0 and 0x4 diverge
        br(32'h8, 3'b000, 4'b1000, 1'b0);
        br(32'hC, 3'b000, 4'b1000, 1'b0);
        idle();
        look(1'b1, 32'h4, "alias_4");
        chk("alias_4_g_const", {31'd0, pred_g}, 32'd1);
        chk("alias_4_b_const", {31'd0, pred_b}, 32'd0);
        look(1'b1, 32'h0, "alias_0");
        chk("alias_0_g_const", {31'd0, pred_g}, 32'd0);

        // 10 branches, 3 mispredicts after a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) br(32'h100 + 32'(i * 4), 3'b000, 4'b1000, (i < 3) ? 1'b0 : 1'b1);
        idle();
        chk("mdl_br", m_br, 32'd10);
        chk("mdl_mp", m_mp, 32'd3);
`ifdef BPU_STATS_EN
        chk("stat_br", st_br_b, 32'(m_br));
        chk("stat_mp", st_mp_b, 32'(m_mp));
        chk("stat_br_g", st_br_g, 32'(m_br));
        chk("stat_mp_g", st_mp_g, 32'(m_mp));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
